demux_pair_scheduler: RTL

//  Single-clock sequencer for the 1:2 sample demux path. Accepts a valid-qualified

---
 rtl/demux_pair_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/demux_pair_scheduler.sv
// -----------------------------------------------------------------------------
// demux_pair_scheduler
//
// Single-clock sequencer for the 1:2 sample demux path. Valid-qualified signed
// samples alternate between an even lane (out1_o) and an odd lane (out2_o).
// Each completed pair is presented together, with a one-cycle out_valid_o strobe.
// A slip command drops one sample so downstream logic can realign the
// even/odd pairing. A wrapping pair counter supports monitoring.
//
// Handshake: there is no back-pressure. A sample is taken on every rising edge
// where in_valid_i=1 and the FSM is in EVEN, ODD or SLIPW. In IDLE, samples are
// ignored. out_valid_o and slip_ack_o are single-cycle strobes with no ready.
//
// Ports
//   clk_i        sole clock, rising edge
//   res_b_i      synchronous active-low reset
//   en_i         scheduler enable; low forces IDLE
//   in_valid_i   in_i carries a sample this cycle
//   in_i         signed sample, BW+4 bits
//   slip_i       drop the next accepted sample, discard any held half-pair
//   out1_o       even-lane sample of the last pair (registered)
//   out2_o       odd-lane sample of the last pair (registered)
//   out_valid_o  one-cycle strobe: out1_o/out2_o hold a new pair
//   phase_o      0 = next sample is even, 1 = next sample is odd
//   slip_ack_o   one-cycle strobe: a sample was dropped for a slip
//   pair_cnt_o   pairs emitted, wraps modulo 2^CNTW
//   state_o      current FSM state (debug)
// -----------------------------------------------------------------------------
module demux_pair_scheduler #(
  parameter int BW   = 6,
  parameter int CNTW = 8
) (
  input  logic                 clk_i,
  input  logic                 res_b_i,
  input  logic                 en_i,
  input  logic                 in_valid_i,
  input  logic signed [BW+3:0] in_i,
  input  logic                 slip_i,
  output logic signed [BW+3:0] out1_o,
  output logic signed [BW+3:0] out2_o,
  output logic                 out_valid_o,
  output logic                 phase_o,
  output logic                 slip_ack_o,
  output logic [CNTW-1:0]      pair_cnt_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVEN  = 2'd1,
    ODD   = 2'd2,
    SLIPW = 2'd3
  } state_e;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic signed [BW+3:0]   hold_q,  hold_d;
  logic signed [BW+3:0]   out1_q,  out1_d;
  logic signed [BW+3:0]   out2_q,  out2_d;
  logic                   ov_q,    ov_d;
  logic                   ack_q,   ack_d;
  logic [CNTW-1:0]        cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    ov_d    = 1'b0;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (en_i) state_d = EVEN;
      end

      EVEN, ODD: begin
        if (!en_i) begin
          // Disable wins over slip and pairing; the half-pair is lost.
          state_d = IDLE;
          hold_d  = '0;
        end else if (slip_i) begin
          // Slip wins over pairing: no pair is emitted from ODD.
          hold_d = '0;
          if (in_valid_i) begin
            state_d = EVEN;
            ack_d   = 1'b1;
          end else begin
            state_d = SLIPW;
          end
        end else if (in_valid_i) begin
          if (state_q == EVEN) begin
            hold_d  = in_i;
            state_d = ODD;
          end else begin
            out1_d  = hold_q;
            out2_d  = in_i;
            ov_d    = 1'b1;
            cnt_d   = cnt_q + CNT_ONE;
            state_d = EVEN;
          end
        end
      end

      SLIPW: begin
        // A further slip here is ignored: only one sample is ever dropped.
        if (!en_i) begin
          state_d = IDLE;
        end else if (in_valid_i) begin
          ack_d   = 1'b1;
          state_d = EVEN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!res_b_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      ov_q    <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      ov_q    <= ov_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out1_o      = out1_q;
  assign out2_o      = out2_q;
  assign out_valid_o = ov_q;
  assign slip_ack_o  = ack_q;
  assign pair_cnt_o  = cnt_q;
  // The next sample is odd exactly when a half-pair is held.
  assign phase_o     = (state_q == ODD);
  assign state_o     = state_q;

endmodule
